// File: rtl/multicycle_alu_pkg.sv
// Shared ALU op-code encoding (also used by the ALU control unit) and execute-stage FSM states.
package multicycle_alu_pkg;

    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_NOR      = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0100;
    localparam logic [3:0] OP_INC      = 4'b0101;
    localparam logic [3:0] OP_MULTPLUS = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

endpackage

// File: rtl/multicycle_alu_mult_shift_add.sv
// Unsigned shift-add multiplier, one partial-product step per cycle; NBits steps after load.
// No backpressure: the caller owns sequencing; last flags the final step.
module mult_shift_add #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [NBits-1:0] a,
    input  logic [NBits-1:0] b,
    output logic [NBits-1:0] product,
    output logic             last
);

    localparam int CW = $clog2(NBits);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBits - 1);

    logic [NBits-1:0] mcand_q, mcand_d;
    logic [NBits-1:0] mplier_q, mplier_d;
    logic [NBits-1:0] prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = a;
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            // Bits shifted out of the multiplicand are dropped: only the low NBits matter.
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = prod_q;
    assign last    = step && (cnt_q == LAST_CNT);

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: logic/arith ops in 1 cycle, MULTPLUS (A*B+A) in NBits+2 cycles.
// Start is only honoured in IDLE; Start while Busy is dropped, never queued.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ALUOperation,
    input  logic [NBits-1:0] A,
    input  logic [NBits-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [NBits-1:0] ALUResult,
    output logic             Zero,
    output logic             IllegalOp
);

    state_t           state_q, state_d;
    logic [NBits-1:0] a_q, a_d;
    logic [NBits-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [NBits-1:0] mul_product;

    assign mul_load = Start && (state_q == ST_IDLE) && (ALUOperation == OP_MULTPLUS);
    assign mul_step = (state_q == ST_MUL);

    mult_shift_add #(.NBits(NBits)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .step    (mul_step),
        .a       (A),
        .b       (B),
        .product (mul_product),
        .last    (mul_last)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    illegal_d = 1'b0;
                    if (ALUOperation == OP_MULTPLUS) begin
                        a_d     = A;
                        busy_d  = 1'b1;
                        state_d = ST_MUL;
                    end else begin
                        done_d = 1'b1;
                        case (ALUOperation)
                            OP_AND:  result_d = A & B;
                            OP_OR:   result_d = A | B;
                            OP_NOR:  result_d = ~(A | B);
                            OP_ADD:  result_d = A + B;
                            OP_SUB:  result_d = A - B;
                            OP_INC:  result_d = A + {{(NBits-1){1'b0}}, 1'b1};
                            default: begin
                                result_d  = '0;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) state_d = ST_ACC;
            end
            ST_ACC: begin
                // Multiplier holds the full product here; the accumulate uses the operand latched at issue.
                result_d = mul_product + a_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign IllegalOp = illegal_q;

endmodule
